// File: rtl/tt_um_a_0_seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Optional DIV_EARLY_EXIT_EN: A < B finishes at the start edge.
module tt_um_a_0_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_dbz;

    logic             w_ld_a;
    logic             w_ld_b;
    logic             w_start;
    logic             w_sel;
    logic             w_ld;
    logic             w_bz;
    logic             w_small;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH:0]   w_shift;
    logic             w_unused;

    assign w_ld_a  = uio_in[0];
    assign w_ld_b  = uio_in[1];
    assign w_start = uio_in[2];
    assign w_sel   = uio_in[3];
    assign w_ld    = w_ld_a | w_ld_b;
    assign w_bz    = (r_b == '0);
    assign w_small = EARLY && (r_a < r_b);

    // Trial subtraction: bring the next dividend bit into the remainder.
    assign w_trial    = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_ge       = (w_trial >= {1'b0, r_b});
    assign w_rem_next = w_ge ? (w_trial - {1'b0, r_b}) : w_trial;
    assign w_shift    = {r_q, w_ge};

    assign uo_out   = w_sel ? 8'(r_rem[WIDTH-1:0]) : 8'(r_q);
    assign uio_out  = {1'b0, r_dbz, (r_state == S_DONE),
                       (r_state == S_CALC), 4'b0000};
    assign uio_oe   = 8'hF0;
    assign w_unused = &{1'b0, ena, ui_in, uio_in[7:4], r_rem[WIDTH]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode: start wins over load; loads leave DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    if (w_bz || w_small) w_next = S_DONE;
                    else                 w_next = S_CALC;
                end else if (w_ld) begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture and shift/subtract datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_q   <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (r_state == S_CALC) begin
            r_rem <= w_rem_next;
            r_q   <= w_shift[WIDTH-1:0];
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end else begin
            if (w_ld_a) r_a <= ui_in[WIDTH-1:0];
            if (w_ld_b) r_b <= ui_in[WIDTH-1:0];
            if (w_start) begin
                if (w_bz) begin
                    r_q   <= '1;
                    r_rem <= {1'b0, r_a};
                    r_dbz <= 1'b1;
                end else if (w_small) begin
                    r_q   <= '0;
                    r_rem <= {1'b0, r_a};
                    r_dbz <= 1'b0;
                end else begin
                    r_q   <= r_a;
                    r_rem <= '0;
                    r_cnt <= CW'(WIDTH - 1);
                    r_dbz <= 1'b0;
                end
            end else if (w_ld) begin
                r_dbz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tt_um_a_0_seq_divider.sv
// Scoreboard bench for the sequential divider.
// Expected quotient/remainder/latency come from a reference model.
module tb_tt_um_a_0_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena = 1'b1;

    always #5 clk = ~clk;

    tt_um_a_0_seq_divider dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena)
    );

    typedef struct {
        int q;
        int r;
        int dbz;
        int busy;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        ui_in  = a;
        uio_in = 8'h01;
        tick;
        ui_in  = b;
        uio_in = 8'h02;
        tick;
        uio_in = 8'h00;
    endtask

    // Pulse start for one edge; optionally push the model result.
    task automatic launch(input int a, input int b, input bit push);
        exp_t e;
        if (b == 0) begin
            e.q = 255; e.r = a; e.dbz = 1; e.busy = 0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 0; e.busy = 8;
`ifdef DIV_EARLY_EXIT_EN
            if (a < b) e.busy = 0;
`endif
        end
        if (push) sb.push_back(e);
        uio_in = 8'h04;
        tick;
        uio_in = 8'h00;
    endtask

    // Wait for done, then pop and compare against the scoreboard.
    task automatic finish_op(input string tag, input int nb0);
        exp_t e;
        int   nb;
        int   n;
        nb = nb0;
        n  = 0;
        e  = sb.pop_front();
        if (nb0 == 0) check({tag, "_done_e0"}, int'(uio_out[5]),
                            (e.busy == 0) ? 1 : 0);
        while (!uio_out[5] && n < 40) begin
            if (uio_out[4]) nb++;
            n++;
            tick;
        end
        check({tag, "_done"}, int'(uio_out[5]), 1);
        check({tag, "_busy"}, nb, e.busy);
        check({tag, "_dbz"}, int'(uio_out[6]), e.dbz);
        uio_in = 8'h00;
        #1;
        check({tag, "_q"}, int'(uo_out), e.q);
        uio_in = 8'h08;
        #1;
        check({tag, "_r"}, int'(uo_out), e.r);
        uio_in = 8'h00;
        tick;
    endtask

    task automatic do_op(input string tag, input int a, input int b);
        load(8'(a), 8'(b));
        launch(a, b, 1'b1);
        finish_op(tag, 0);
    endtask

    initial begin
        int a;
        int b;
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick;
        tick;
        check("rst_uo", int'(uo_out), 0);
        check("rst_uio", int'(uio_out), 0);
        check("rst_oe", int'(uio_oe), 8'hF0);
        rst_n = 1'b1;
        tick;

        do_op("basic", 200, 7);
        do_op("max_b1", 255, 1);
        do_op("eq", 255, 255);
        launch(255, 255, 1'b1);
        finish_op("start_in_done", 0);
        do_op("dbz", 13, 0);
        check("dbz_oe", int'(uio_out & 8'h8F), 0);
        do_op("small", 5, 9);

        ui_in  = 8'd50;
        uio_in = 8'h03;
        tick;
        uio_in = 8'h00;
        launch(50, 50, 1'b1);
        finish_op("ld_both", 0);

        load(8'd200, 8'd7);
        launch(200, 7, 1'b1);
        tick;
        tick;
        tick;
        ui_in  = 8'd99;
        uio_in = 8'h05;
        tick;
        uio_in = 8'h00;
        finish_op("ign_calc", 4);
        launch(200, 7, 1'b1);
        finish_op("a_kept", 0);

        load(8'd200, 8'd7);
        launch(200, 7, 1'b0);
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("abort_busy", int'(uio_out[4]), 0);
        check("abort_done", int'(uio_out[5]), 0);
        check("abort_q", int'(uo_out), 0);
        uio_in = 8'h08;
        #1;
        check("abort_r", int'(uo_out), 0);
        uio_in = 8'h00;
        tick;
        do_op("after_rst", 100, 10);

        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 40));
            do_op("rand", a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tt_um_a_0_seq_divider.md
Name: tt_um_a_0_seq_divider

Overview:
- Iterative restoring unsigned divider. It is the inverse-operation companion to the team's array multiplier and sits in the same TinyTapeout tile wrapper.
- Operands are loaded through ui_in with strobes on uio_in. Division runs at one quotient bit per clock.
- Quotient or remainder is presented on uo_out. Status flags are presented on the upper uio pins.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range 1..8. Operands occupy ui_in[WIDTH-1:0]; unused upper result bits drive 0.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ui_in  input  8  operand data bus.
- uo_out  output  8  result: quotient when uio_in[3]=0, remainder when uio_in[3]=1.
- uio_in  input  8  [0]=ld_a (dividend), [1]=ld_b (divisor), [2]=start, [3]=sel; [7:4] unused.
- uio_out  output  8  [4]=busy, [5]=done, [6]=dbz (divide-by-zero); all other bits 0.
- uio_oe  output  8  constant 8'hF0.
- ena  input  1  unused.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n), sampled only on the rising edge of clk.
- Reset:
  - State = IDLE.
  - Operand A, operand B, quotient, remainder and step counter all = 0.
  - busy=0, done=0, dbz=0, uo_out=0.
  - Reset asserted mid-calculation aborts the operation immediately; results read 0.
- Registered loads (IDLE or DONE only):
  - ld_a=1 captures A <= ui_in[WIDTH-1:0].
  - ld_b=1 captures B <= ui_in[WIDTH-1:0].
  - ld_a and ld_b both high captures the same value into both.
  - Any load in DONE clears done and dbz and returns to IDLE.
  - Loads in CALC are ignored.
- FSM states: IDLE, CALC, DONE.
- IDLE/DONE with start=1 at edge E0:
  - The operation uses the A and B held before this edge. A load in the same cycle only affects the next operation.
  - If B==0: next state DONE; dbz=1, quotient = all-ones (WIDTH bits), remainder = A. Done is visible after E0 (zero compute cycles).
  - Otherwise: next state CALC; counter = WIDTH-1, partial remainder = 0, shift register = A, done=0, dbz=0.
- CALC, each edge E1..E_WIDTH:
  - trial = {rem, msb of shift}.
  - If trial >= B: rem = trial - B and quotient bit = 1; else rem = trial and quotient bit = 0.
  - Shift the quotient bit in at the LSB.
  - At counter==0 the next state is DONE; otherwise decrement the counter.
- Timing: busy=1 exactly WIDTH cycles (after E0 through E_WIDTH). done=1 from E_WIDTH onward.
- Overlap rules: start during CALC is ignored. start in DONE launches a new operation and clears done at that edge.
- Result holding: results are held stable in DONE until the next start or load.
- Output path: uo_out = registered quotient/remainder selected combinationally by sel, zero-extended to 8 bits.
- Arithmetic: internal remainder datapath is WIDTH+1 bits; results are exact for all A, B with B != 0.

Optional Feature:
- DIV_EARLY_EXIT_EN defined: at E0, if B != 0 and A < B, go directly to DONE with quotient=0, remainder=A, busy never asserted (same latency as the dbz path).
- Undefined: every B != 0 operation takes exactly WIDTH CALC cycles; results are identical either way.

Test Plan:
- Basic divide: ld_a 200, ld_b 7, start -> busy high 8 cycles, then done=1; sel=0 uo_out=28, sel=1 uo_out=4, dbz=0.
- Extremes: A=255, B=1 -> q=255, r=0; then A=255, B=255 with start in DONE -> done drops for 8 cycles, then q=1, r=0.
- Divide by zero: A=13, B=0, start -> done and dbz high the cycle after E0, busy never high; q=255, r=13.
- Small dividend: A=5, B=9 -> q=0, r=5; latency 8 busy cycles without DIV_EARLY_EXIT_EN, 0 busy cycles with it.
- Ignored inputs during CALC: ld_a=99 and start pulsed mid-CALC of 200/7 -> result still 28 r 4; A still 200 afterwards.
- Reset mid-operation: rst_n low for 1 cycle at step 4 -> next cycle busy=0, done=0, uo_out=0; a fresh 100/10 then yields q=10, r=0.
